store_merge_rmw: RTL and testbench
==================================

STORE_MERGE_RMW -- requirements
Module: store_merge_rmw

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter BIG_ENDIAN, default 1; 1 = byte offset 0 occupies the MSB lane, 0 = byte offset 0 occupies the LSB lane.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1, store request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-009 SHALL have port req_size, input, 2; 00 byte, 01 half, 10 word (32b), 11 dword (64b, legal only when DATA_W=64).
REQ-010 SHALL have port req_data, input, DATA_W, store value right-aligned (LSBs).
REQ-011 SHALL have port done, output, 1, one-cycle pulse on store completion.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on a rejected request.
REQ-013 SHALL have ports mem_addr (output, ADDR_W, word-aligned: offset bits zero), mem_rd_valid/mem_rd_ready (output/input, 1), mem_rdata_valid (input, 1), mem_rdata (input, DATA_W).
REQ-014 SHALL have ports mem_wr_valid (output, 1), mem_wr_ready (input, 1), mem_wdata (output, DATA_W).

Function
REQ-015 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR, with req_ready=1 only in IDLE.
REQ-016 SHALL, on acceptance, register addr, size and data; OFF = addr[log2(DATA_W/8)-1:0].
REQ-017 SHALL reject (err pulse the cycle after acceptance, no memory traffic, stay IDLE) when OFF is not a multiple of the access size in bytes, or when size=11 and DATA_W=32.
REQ-018 SHALL go IDLE->WR for a full-width store (size equals DATA_W), with mem_wdata = req_data, skipping the read.
REQ-019 SHALL go IDLE->RD_REQ for sub-word stores; mem_rd_valid asserted the cycle after acceptance and held until mem_rd_ready.
REQ-020 SHALL go RD_REQ->RD_WAIT on mem_rd_ready; RD_WAIT->WR on mem_rdata_valid, capturing the merged word.
REQ-021 SHALL accept mem_rdata_valid in the same cycle as the mem_rd_ready handshake (zero-latency memory) and go directly to WR.
REQ-022 SHALL form the merged word by replacing the size-byte lane group selected by OFF and BIG_ENDIAN with the low bytes of req_data; all other bytes SHALL equal mem_rdata.
REQ-023 SHALL hold mem_wr_valid, mem_wdata and mem_addr stable in WR until mem_wr_ready; on that handshake, pulse done and return to IDLE.
REQ-024 SHALL keep mem_addr stable from RD_REQ through the end of WR.
REQ-025 SHALL never assert mem_rd_valid and mem_wr_valid together.
REQ-026 SHALL give a minimum latency, acceptance to done, of 1 cycle for a full-width store and 3 cycles for a sub-word store with 0-wait memory.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, with req_ready=1 and done, err, mem_rd_valid, mem_wr_valid = 0; mem_addr and mem_wdata SHALL be forced to 0.
REQ-028 SHALL abandon an in-flight store on reset mid-operation, with no done pulse and no write issued after deassertion.

Structure
REQ-029 SHALL take the size encodings and the state enum from shared package mips_mem_pkg.
REQ-030 SHALL place the merge in a combinational sub-module byte_lane_merge (parameters DATA_W, BIG_ENDIAN; inputs org, off, size, val; output result).

Verification
REQ-031 SHALL test SB with BIG_ENDIAN=1, DATA_W=32, addr 0x1001, data 0xAA, memory 0x11223344: mem_wdata 0x11AA3344 at addr 0x1000, then a done pulse.
REQ-032 SHALL test SB with BIG_ENDIAN=0, same stimulus: mem_wdata 0x1122AA44.
REQ-033 SHALL test SH with BIG_ENDIAN=1, addr 0x2002, data 0xBEEF, memory 0x11223344: 0x1122BEEF; SH at addr 0x2001 gives an err pulse with no mem_rd_valid or mem_wr_valid.
REQ-034 SHALL test SW with DATA_W=32, data 0xDEADBEEF: no read, mem_wr_valid one cycle after acceptance, done one cycle after mem_wr_ready.
REQ-035 SHALL test DATA_W=64, BIG_ENDIAN=1, SW at OFF 4, data 0xCAFEF00D, memory 0x0011223344556677: 0x00112233CAFEF00D.
REQ-036 SHALL test rst_n pulsed low during RD_WAIT: outputs reach reset values immediately, with no write or done after release.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared memory-access definitions: store size encodings, the store FSM state
// enum and small helpers that decode a size field.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR      = 2'd3
  } state_e;

  function automatic int unsigned size_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

  // Low-address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    return 3'((4'd1 << size) - 4'd1);
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: replaces the lanes addressed by off/size
// (endianness chosen by BIG_ENDIAN) with the low bytes of val.
module byte_lane_merge
  import mips_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int NB        = DATA_W / 8,
  localparam int OFF_W     = $clog2(NB)
) (
  input  logic [DATA_W-1:0] org,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] val,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    int nbytes;
    int pos;
    int j;
    int src;
    // NOTE: every variable written in always_comb is assigned before any
    // conditional path, otherwise synthesis infers a latch.
    result = org;
    nbytes = int'(size_bytes(size));
    if (nbytes > NB) nbytes = NB;
    pos = 0;
    j   = 0;
    src = 0;
    for (int lane = 0; lane < NB; lane++) begin
      // pos is the byte offset within the word that this lane holds.
      pos = BIG_ENDIAN ? (NB - 1 - lane) : lane;
      j   = pos - int'(off);
      if (j >= 0 && j < nbytes) begin
        src = BIG_ENDIAN ? (nbytes - 1 - j) : j;
        result[lane*8 +: 8] = val[src*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/store_merge_rmw.sv
// Store unit for a word-wide memory: full-width stores write directly,
// sub-word stores do read-modify-write with a byte-lane merge.
module store_merge_rmw
  import mips_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] merged;

  logic [OFF_W-1:0]  req_off;
  logic              misaligned;
  logic              bad_size;
  logic              full_width;

  assign req_off    = req_addr[OFF_W-1:0];
  assign misaligned = (3'(req_off) & size_mask(req_size)) != 3'd0;
  assign bad_size   = (req_size == SIZE_D) && (DATA_W == 32);
  assign full_width = (32'd8 << req_size) == 32'(DATA_W);

  byte_lane_merge #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_merge (
    .org    (mem_rdata),
    .off    (off_q),
    .size   (size_q),
    .val    (data_q),
    .result (merged)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_d      = data_q;
    off_d       = off_q;
    size_d      = size_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned || bad_size) begin
            err_d = 1'b1;
          end else begin
            mem_addr_d = req_addr & ~ADDR_W'(NB - 1);
            data_d     = req_data;
            off_d      = req_off;
            size_d     = req_size;
            if (full_width) begin
              mem_wdata_d = req_data;
              state_d     = ST_WR;
            end else begin
              state_d = ST_RD_REQ;
            end
          end
        end
      end
      ST_RD_REQ: begin
        // Zero-latency memory may return data in the request cycle.
        if (mem_rd_ready) begin
          if (mem_rdata_valid) begin
            mem_wdata_d = merged;
            state_d     = ST_WR;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (mem_rdata_valid) begin
          mem_wdata_d = merged;
          state_d     = ST_WR;
        end
      end
      ST_WR: begin
        if (mem_wr_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_q      <= '0;
      off_q       <= '0;
      size_q      <= SIZE_B;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      data_q      <= data_d;
      off_q       <= off_d;
      size_q      <= size_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign mem_rd_valid = (state_q == ST_RD_REQ);
  assign mem_wr_valid = (state_q == ST_WR);
  assign done         = done_q;
  assign err          = err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Scoreboard bench for store_merge_rmw: three instances (32b big-endian,
// 32b little-endian, 64b big-endian) driven with directed store vectors.
module tb_store_merge_rmw;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          inst;
    int          kind;
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] mem;
    bit          zl;
    bit          exp_err;
    bit          exp_rd;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
    int          exp_n;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        zl;
  logic        hold;
  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic [1:0]  req_size  [3];
  logic [63:0] req_data  [3];
  logic        rd_ready  [3];
  logic        wr_ready  [3];
  logic [63:0] rdata     [3];

  wire         req_ready_w   [3];
  wire         done_w        [3];
  wire         err_w         [3];
  wire         rd_valid_w    [3];
  wire         wr_valid_w    [3];
  wire         rdata_valid_w [3];
  wire  [31:0] maddr_w       [3];
  wire  [63:0] wdata_w       [3];

  exp_t sb[$];
  vec_t vecs[$];
  int   compared;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = (g == 2) ? 64 : 32;
    localparam bit BE = (g == 1) ? 1'b0 : 1'b1;
    wire [DW-1:0] wd;
    logic         rv_q;

    // Memory model: data returns the cycle after the read handshake, or in
    // the same cycle when zl is set; hold suppresses it entirely.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rv_q <= 1'b0;
      else        rv_q <= rd_valid_w[g] && rd_ready[g];
    end
    assign rdata_valid_w[g] = !hold && (zl ? (rd_valid_w[g] && rd_ready[g]) : rv_q);
    assign wdata_w[g]       = 64'(wd);

    store_merge_rmw #(
      .DATA_W     (DW),
      .ADDR_W     (32),
      .BIG_ENDIAN (BE)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid[g]),
      .req_ready       (req_ready_w[g]),
      .req_addr        (req_addr[g]),
      .req_size        (req_size[g]),
      .req_data        (req_data[g][DW-1:0]),
      .done            (done_w[g]),
      .err             (err_w[g]),
      .mem_addr        (maddr_w[g]),
      .mem_rd_valid    (rd_valid_w[g]),
      .mem_rd_ready    (rd_ready[g]),
      .mem_rdata_valid (rdata_valid_w[g]),
      .mem_rdata       (rdata[g][DW-1:0]),
      .mem_wr_valid    (wr_valid_w[g]),
      .mem_wr_ready    (wr_ready[g]),
      .mem_wdata       (wd)
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int i, input int kind, input logic [31:0] a, input logic [63:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      errors++;
      $display("FAIL unexpected_event: inst %0d kind %0d addr 0x%0h data 0x%0h, expected nothing", i, kind, a, d);
    end else begin
      e = sb.pop_front();
      check($sformatf("sb_inst"), 64'(i), 64'(e.inst));
      check($sformatf("sb_kind_inst%0d", i), 64'(kind), 64'(e.kind));
      if (e.kind == K_WR && kind == K_WR) begin
        check($sformatf("sb_wr_addr_inst%0d", i), 64'(a), 64'(e.addr));
        check($sformatf("sb_wr_data_inst%0d", i), d, e.data);
      end
    end
  endtask

  // Monitor: every write handshake, done and err pulse is matched in order.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (rd_valid_w[i] && wr_valid_w[i]) begin
          errors++;
          $display("FAIL rd_wr_overlap: inst %0d has both valids high, expected at most one", i);
        end
        if (wr_valid_w[i] && wr_ready[i]) pop_cmp(i, K_WR, maddr_w[i], wdata_w[i]);
        if (done_w[i]) pop_cmp(i, K_DONE, 32'h0, 64'h0);
        if (err_w[i])  pop_cmp(i, K_ERR, 32'h0, 64'h0);
      end
    end
  end

  function automatic vec_t mk(input int inst, input logic [31:0] addr, input logic [1:0] size,
                              input logic [63:0] data, input logic [63:0] mem, input bit zlat,
                              input bit e_err, input bit e_rd, input logic [31:0] e_addr,
                              input logic [63:0] e_wdata, input int e_n);
    vec_t v;
    v.inst = inst; v.addr = addr; v.size = size; v.data = data; v.mem = mem; v.zl = zlat;
    v.exp_err = e_err; v.exp_rd = e_rd; v.exp_addr = e_addr; v.exp_wdata = e_wdata; v.exp_n = e_n;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int i;
    int n;
    bit saw_rd;
    bit finished;
    i = v.inst;
    rdata[i] = v.mem;
    zl = v.zl;
    if (v.exp_err) begin
      sb.push_back('{i, K_ERR, 32'h0, 64'h0});
    end else begin
      sb.push_back('{i, K_WR, v.exp_addr, v.exp_wdata});
      sb.push_back('{i, K_DONE, 32'h0, 64'h0});
    end
    @(negedge clk);
    check($sformatf("v%0d_req_ready", idx), 64'(req_ready_w[i]), 64'd1);
    req_valid[i] = 1'b1;
    req_addr[i]  = v.addr;
    req_size[i]  = v.size;
    req_data[i]  = v.data;
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    n = 0;
    saw_rd = 1'b0;
    finished = 1'b0;
    while (n < 40 && !finished) begin
      @(negedge clk);
      n++;
      if (rd_valid_w[i]) saw_rd = 1'b1;
      if (done_w[i] || err_w[i]) finished = 1'b1;
    end
    check($sformatf("v%0d_completed", idx), 64'(finished), 64'd1);
    check($sformatf("v%0d_latency", idx), 64'(n), 64'(v.exp_n));
    check($sformatf("v%0d_read_issued", idx), 64'(saw_rd), 64'(v.exp_rd));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0;
    errors   = 0;
    rst_n    = 1'b0;
    zl       = 1'b0;
    hold     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
      req_size[i]  = '0;
      req_data[i]  = '0;
      rd_ready[i]  = 1'b1;
      wr_ready[i]  = 1'b1;
      rdata[i]     = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_req_ready_%0d", i), 64'(req_ready_w[i]), 64'd1);
      check($sformatf("rst_rd_valid_%0d", i), 64'(rd_valid_w[i]), 64'd0);
      check($sformatf("rst_wr_valid_%0d", i), 64'(wr_valid_w[i]), 64'd0);
      check($sformatf("rst_done_err_%0d", i), 64'({done_w[i], err_w[i]}), 64'd0);
      check($sformatf("rst_mem_addr_%0d", i), 64'(maddr_w[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // inst, addr, size, data, mem, zl, err, rd, exp addr, exp wdata, done negedge
    vecs.push_back(mk(0, 32'h1001, 2'b00, 64'hAA, 64'h11223344, 0, 0, 1, 32'h1000, 64'h11AA3344, 4));
    vecs.push_back(mk(1, 32'h1001, 2'b00, 64'hAA, 64'h11223344, 0, 0, 1, 32'h1000, 64'h1122AA44, 4));
    vecs.push_back(mk(0, 32'h2002, 2'b01, 64'hBEEF, 64'h11223344, 0, 0, 1, 32'h2000, 64'h1122BEEF, 4));
    vecs.push_back(mk(0, 32'h2001, 2'b01, 64'hBEEF, 64'h11223344, 0, 1, 0, 32'h0, 64'h0, 1));
    vecs.push_back(mk(1, 32'h2002, 2'b01, 64'hFFFFBEEF, 64'h11223344, 0, 0, 1, 32'h2000, 64'hBEEF3344, 4));
    vecs.push_back(mk(0, 32'h4004, 2'b10, 64'hDEADBEEF, 64'h99999999, 0, 0, 0, 32'h4004, 64'hDEADBEEF, 2));
    vecs.push_back(mk(0, 32'h4000, 2'b11, 64'h1234, 64'h0, 0, 1, 0, 32'h0, 64'h0, 1));
    vecs.push_back(mk(0, 32'h4002, 2'b10, 64'h1234, 64'h0, 0, 1, 0, 32'h0, 64'h0, 1));
    vecs.push_back(mk(2, 32'h8004, 2'b10, 64'hCAFEF00D, 64'h0011223344556677, 0, 0, 1, 32'h8000, 64'h00112233CAFEF00D, 4));
    vecs.push_back(mk(2, 32'h8006, 2'b01, 64'hA1B2, 64'h0011223344556677, 0, 0, 1, 32'h8000, 64'h001122334455A1B2, 4));
    vecs.push_back(mk(2, 32'h8008, 2'b11, 64'h0123456789ABCDEF, 64'h5555, 0, 0, 0, 32'h8008, 64'h0123456789ABCDEF, 2));
    vecs.push_back(mk(2, 32'h8003, 2'b10, 64'h1, 64'h0, 0, 1, 0, 32'h0, 64'h0, 1));
    vecs.push_back(mk(2, 32'h800D, 2'b00, 64'h5A, 64'h0011223344556677, 0, 0, 1, 32'h8008, 64'h00112233445A6677, 4));
    vecs.push_back(mk(0, 32'h1003, 2'b00, 64'h55, 64'h11223344, 1, 0, 1, 32'h1000, 64'h11223355, 3));
    vecs.push_back(mk(1, 32'h1000, 2'b00, 64'h12345677, 64'h11223344, 0, 0, 1, 32'h1000, 64'h11223377, 4));
    vecs.push_back(mk(1, 32'h1006, 2'b01, 64'hCD12, 64'h11223344, 0, 0, 1, 32'h1004, 64'hCD123344, 4));
    foreach (vecs[k]) run_vec(vecs[k], k);
    zl = 1'b0;

    // Full-width store with a stalled write port: wr_valid the cycle after
    // acceptance, held stable, done the cycle after the write handshake.
    wr_ready[0] = 1'b0;
    sb.push_back('{0, K_WR, 32'h3000, 64'hDEADBEEF});
    sb.push_back('{0, K_DONE, 32'h0, 64'h0});
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h3000;
    req_size[0]  = 2'b10;
    req_data[0]  = 64'hDEADBEEF;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("sw_wr_valid_first", 64'(wr_valid_w[0]), 64'd1);
    check("sw_no_read", 64'(rd_valid_w[0]), 64'd0);
    repeat (2) @(negedge clk);
    check("sw_wr_valid_held", 64'(wr_valid_w[0]), 64'd1);
    check("sw_wdata_held", wdata_w[0], 64'hDEADBEEF);
    check("sw_addr_held", 64'(maddr_w[0]), 64'h3000);
    @(posedge clk);
    #1 wr_ready[0] = 1'b1;
    @(negedge clk);
    check("sw_done_not_early", 64'(done_w[0]), 64'd0);
    @(negedge clk);
    check("sw_done_pulse", 64'(done_w[0]), 64'd1);
    @(negedge clk);
    check("sw_done_one_cycle", 64'(done_w[0]), 64'd0);

    // Reset while waiting for read data: abandon the store silently.
    hold = 1'b1;
    rdata[0] = 64'h11223344;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h1001;
    req_size[0]  = 2'b00;
    req_data[0]  = 64'hAA;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("rw_rd_valid", 64'(rd_valid_w[0]), 64'd1);
    @(negedge clk);
    check("rw_in_rd_wait", 64'({rd_valid_w[0], wr_valid_w[0], req_ready_w[0]}), 64'd0);
    check("rw_addr_before_rst", 64'(maddr_w[0]), 64'h1000);
    #1 rst_n = 1'b0;
    #1;
    check("rw_rst_req_ready", 64'(req_ready_w[0]), 64'd1);
    check("rw_rst_valids", 64'({rd_valid_w[0], wr_valid_w[0]}), 64'd0);
    check("rw_rst_done_err", 64'({done_w[0], err_w[0]}), 64'd0);
    check("rw_rst_mem_addr", 64'(maddr_w[0]), 64'd0);
    check("rw_rst_mem_wdata", wdata_w[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold  = 1'b0;
    repeat (10) @(negedge clk);
    check("rw_post_idle", 64'({req_ready_w[0], wr_valid_w[0]}), 64'b10);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
